serial_word_tx: RTL and testbench



---
 rtl/serial_word_tx.sv | 165 ++++++++++++++++
 tb/tb_serial_word_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter: takes one word on a valid/ready handshake and
// streams it out one bit per transfer, tagged with the bit's word position.
module serial_word_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ser_out,
    output logic                          ser_valid,
    input  logic                          ser_ready,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_idx,
    output logic                          ser_first,
    output logic                          ser_last,
    output logic                          busy
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(DATA_WIDTH - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    generate
        if (DATA_WIDTH < 2) begin : g_bad_width
            $error("serial_word_tx: DATA_WIDTH must be 2 or more");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
            $error("serial_word_tx: GAP_CYCLES must be in 0..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   ordered;
    logic [DATA_WIDTH-2:0]   rem_reg, rem_next;
    logic [IDX_W-1:0]        cnt_reg, cnt_next, cnt_inc;
    logic [7:0]              gap_reg, gap_next;
    logic [IDX_W-1:0]        idx_next;
    logic                    out_next, valid_next, first_next, last_next;
    logic                    bit_xfer, last_xfer, load, drop;

    // Reorder the word so transmission always proceeds from ordered[0] upward.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_order
            if (LSB_FIRST != 0) begin : g_lsb
                assign ordered[gi] = in_data[gi];
            end else begin : g_msb
                assign ordered[gi] = in_data[DATA_WIDTH-1-gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        out_next   = ser_out;
        valid_next = ser_valid;
        idx_next   = bit_idx;
        first_next = ser_first;
        last_next  = ser_last;
        in_ready   = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        cnt_inc    = cnt_reg + 1'b1;
        bit_xfer   = ser_valid && ser_ready;
        last_xfer  = bit_xfer && (cnt_reg == LAST_CNT);

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (last_xfer) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        gap_next   = 8'd0;
                        drop       = 1'b1;
                    end else begin
                        // Accepting here gives back-to-back words with no bubble.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                            drop       = 1'b1;
                        end
                    end
                end else if (bit_xfer) begin
                    rem_next   = rem_reg >> 1;
                    cnt_next   = cnt_inc;
                    out_next   = rem_reg[0];
                    idx_next   = (LSB_FIRST != 0) ? cnt_inc : LAST_CNT - cnt_inc;
                    first_next = 1'b0;
                    last_next  = (cnt_inc == LAST_CNT);
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                    gap_next   = 8'd0;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            state_next = SHIFT;
            rem_next   = ordered[DATA_WIDTH-1:1];
            cnt_next   = '0;
            out_next   = ordered[0];
            valid_next = 1'b1;
            idx_next   = (LSB_FIRST != 0) ? '0 : LAST_CNT;
            first_next = 1'b1;
            last_next  = 1'b0;
        end

        if (drop) begin
            out_next   = 1'b0;
            valid_next = 1'b0;
            idx_next   = '0;
            first_next = 1'b0;
            last_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            gap_reg   <= 8'd0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            bit_idx   <= '0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
            gap_reg   <= gap_next;
            ser_out   <= out_next;
            ser_valid <= valid_next;
            bit_idx   <= idx_next;
            ser_first <= first_next;
            ser_last  <= last_next;
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: four parameterisations share one stimulus
// bus; each scenario checks the instance it targets against hand-computed bits.
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic       ir [4];
    logic       so [4];
    logic       sv [4];
    logic       sf [4];
    logic       sl [4];
    logic       bz [4];
    logic [2:0] idx [4];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // 0: LSB first, no gap   1: MSB first, no gap   2: LSB first, gap 3   3: 5-bit word
    serial_word_tx #(.DATA_WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(0)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .ser_ready(ser_ready), .bit_idx(idx[0]),
        .ser_first(sf[0]), .ser_last(sl[0]), .busy(bz[0]));

    serial_word_tx #(.DATA_WIDTH(8), .LSB_FIRST(0), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .ser_ready(ser_ready), .bit_idx(idx[1]),
        .ser_first(sf[1]), .ser_last(sl[1]), .busy(bz[1]));

    serial_word_tx #(.DATA_WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(3)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .ser_ready(ser_ready), .bit_idx(idx[2]),
        .ser_first(sf[2]), .ser_last(sl[2]), .busy(bz[2]));

    serial_word_tx #(.DATA_WIDTH(5), .LSB_FIRST(1), .GAP_CYCLES(0)) u_d (
        .clk(clk), .rst(rst), .in_data(in_data[4:0]), .in_valid(in_valid), .in_ready(ir[3]),
        .ser_out(so[3]), .ser_valid(sv[3]), .ser_ready(ser_ready), .bit_idx(idx[3]),
        .ser_first(sf[3]), .ser_last(sl[3]), .busy(bz[3]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        in_data   = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present a word for exactly one cycle; returns on the negedge after capture.
    task automatic send(input logic [7:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called on the negedge where the first bit should be visible. seq[k] is the
    // k-th bit on the wire; bit_idx is expected to be idx0 + step*k.
    task automatic check_word(input int u, input logic [7:0] seq, input int n,
                              input int idx0, input int step, input logic rdy_last,
                              input int stall_at, input int stall_len, input string tag);
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ser_ready = 1'b0;
                    check_val({tag, "_stall_valid"}, 32'(sv[u]), 32'd1);
                    check_val({tag, "_stall_bit"}, 32'(so[u]), 32'(seq[k]));
                    check_val({tag, "_stall_idx"}, 32'(idx[u]), 32'(idx0 + step * k));
                    check_val({tag, "_stall_in_ready"}, 32'(ir[u]), 32'd0);
                    @(negedge clk);
                end
            end
            ser_ready = 1'b1;
            check_val({tag, "_valid"}, 32'(sv[u]), 32'd1);
            check_val({tag, "_bit"}, 32'(so[u]), 32'(seq[k]));
            check_val({tag, "_idx"}, 32'(idx[u]), 32'(idx0 + step * k));
            check_val({tag, "_first"}, 32'(sf[u]), 32'(k == 0));
            check_val({tag, "_last"}, 32'(sl[u]), 32'(k == n - 1));
            check_val({tag, "_in_ready"}, 32'(ir[u]), (k == n - 1) ? 32'(rdy_last) : 32'd0);
            check_val({tag, "_busy"}, 32'(bz[u]), 32'd1);
            @(negedge clk);
        end
        $display("word %s on dut %0d: %0d bits checked", tag, u, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap_n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        in_data   = 8'h00;
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check_val("rst_valid", 32'(sv[u]), 32'd0);
            check_val("rst_out", 32'(so[u]), 32'd0);
            check_val("rst_idx", 32'(idx[u]), 32'd0);
            check_val("rst_first", 32'(sf[u]), 32'd0);
            check_val("rst_last", 32'(sl[u]), 32'd0);
            check_val("rst_busy", 32'(bz[u]), 32'd0);
            check_val("rst_in_ready", 32'(ir[u]), 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        // 1: 0xA5 LSB first -> 1,0,1,0,0,1,0,1
        in_data  = 8'hA5;
        in_valid = 1'b1;
        check_val("t1_in_ready_idle", 32'(ir[0]), 32'd1);
        check_val("t1_valid_before", 32'(sv[0]), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check_word(0, 8'hA5, 8, 0, 1, 1'b1, -1, 0, "t1_a5");
        check_val("t1_idle_valid", 32'(sv[0]), 32'd0);
        check_val("t1_idle_busy", 32'(bz[0]), 32'd0);

        // 2: MSB first; 0xA5 -> 1,0,1,0,0,1,0,1 and 0x01 -> seven 0s then 1
        do_reset();
        send(8'hA5);
        check_word(1, 8'hA5, 8, 7, -1, 1'b1, -1, 0, "t2_a5");
        send(8'h01);
        check_word(1, 8'h80, 8, 7, -1, 1'b1, -1, 0, "t2_01");
        check_val("t2_idle_valid", 32'(sv[1]), 32'd0);

        // 3: 0x3C (0,0,1,1,1,1,0,0) with 3 stall cycles on bit 4
        do_reset();
        send(8'h3C);
        check_word(0, 8'h3C, 8, 0, 1, 1'b1, 4, 3, "t3_3c");
        check_val("t3_idle_valid", 32'(sv[0]), 32'd0);

        // 4a: back-to-back 0xFF then 0x00, no gap
        do_reset();
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h00;
        check_word(0, 8'hFF, 8, 0, 1, 1'b1, -1, 0, "t4_ff");
        in_valid = 1'b0;
        check_word(0, 8'h00, 8, 0, 1, 1'b1, -1, 0, "t4_00");
        check_val("t4_idle_valid", 32'(sv[0]), 32'd0);

        // 4b: same with GAP_CYCLES=3 -> 4 idle cycles between words
        do_reset();
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h00;
        check_word(2, 8'hFF, 8, 0, 1, 1'b0, -1, 0, "t4g_ff");
        check_val("t4g_gap_busy", 32'(bz[2]), 32'd1);
        check_val("t4g_gap_in_ready", 32'(ir[2]), 32'd0);
        gap_n = 0;
        while (sv[2] == 1'b0 && gap_n < 20) begin
            gap_n++;
            @(negedge clk);
        end
        check_val("t4g_bubble", 32'(gap_n), 32'd4);
        in_valid = 1'b0;
        check_word(2, 8'h00, 8, 0, 1, 1'b0, -1, 0, "t4g_00");

        // 5: asynchronous reset during bit 3 of 0xAA, then 0x55
        do_reset();
        send(8'hAA);
        repeat (3) @(negedge clk);
        check_val("t5_pre_idx", 32'(idx[0]), 32'd3);
        check_val("t5_pre_bit", 32'(so[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t5_rst_valid", 32'(sv[0]), 32'd0);
        check_val("t5_rst_out", 32'(so[0]), 32'd0);
        check_val("t5_rst_idx", 32'(idx[0]), 32'd0);
        check_val("t5_rst_first", 32'(sf[0]), 32'd0);
        check_val("t5_rst_last", 32'(sl[0]), 32'd0);
        check_val("t5_rst_busy", 32'(bz[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_val("t5_rel_in_ready", 32'(ir[0]), 32'd1);
        check_val("t5_rel_busy", 32'(bz[0]), 32'd0);
        send(8'h55);
        check_word(0, 8'h55, 8, 0, 1, 1'b1, -1, 0, "t5_55");

        // 6: DATA_WIDTH=5; 0x13 -> 1,1,0,0,1 then 0x06 -> 0,1,1,0,0
        do_reset();
        send(8'h13);
        check_word(3, 8'h13, 5, 0, 1, 1'b1, -1, 0, "t6_13");
        send(8'h06);
        check_word(3, 8'h06, 5, 0, 1, 1'b1, -1, 0, "t6_06");
        check_val("t6_idle_valid", 32'(sv[3]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
